// File: rtl/parking_gate_controller_pkg.sv
// Shared definitions for the parking gate front-end and the parking counter.
// Optional barrier-open watchdog is enabled with macro PARKING_GATE_TIMEOUT_EN.
package parking_pkg;

  localparam int unsigned DEF_DEBOUNCE_CYCLES  = 32'd4;
  localparam int unsigned DEF_CARD_WAIT_CYCLES = 32'd16;
  localparam int unsigned DEF_PULSE_CYCLES     = 32'd2;
  localparam int unsigned DEF_OPEN_TIMEOUT     = 32'd64;

  // Total spaces managed by the downstream counter.
  localparam int unsigned PARKING_CAPACITY     = 32'd100;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    CARD       = 3'd1,
    CHECK      = 3'd2,
    OPEN       = 3'd3,
    STROBE_REQ = 3'd4,
    STROBE     = 3'd5,
    HOLD       = 3'd6,
    DRAIN      = 3'd7
  } lane_state_e;

  // Admission decision: exit always passes, entry needs space in the car's zone.
  function automatic logic lane_ok(input logic is_entry, input logic uni,
                                   input logic uni_vacant, input logic pub_vacant);
    logic ok;
    if (!is_entry) begin
      ok = 1'b1;
    end else if (uni) begin
      ok = uni_vacant;
    end else begin
      ok = pub_vacant;
    end
    return ok;
  endfunction

endpackage

// File: rtl/parking_gate_controller_if.sv
// Sensor / reader / counter-facing signal bundle of the parking gate controller.
// gate_timeout exists only when PARKING_GATE_TIMEOUT_EN is defined.
interface parking_gate_if;
  logic loop_in_raw;
  logic loop_out_raw;
  logic card_in_valid;
  logic card_in_uni;
  logic card_out_valid;
  logic card_out_uni;
  logic uni_is_vacated_space;
  logic is_vacated_space;
  logic car_entered;
  logic is_uni_car_entered;
  logic car_exited;
  logic is_uni_car_exited;
  logic barrier_in_open;
  logic barrier_out_open;
  logic entry_denied;
`ifdef PARKING_GATE_TIMEOUT_EN
  logic gate_timeout;
`endif

  // Environment side: drives sensors, readers and vacancy flags.
  modport master (
    output loop_in_raw, loop_out_raw, card_in_valid, card_in_uni,
           card_out_valid, card_out_uni, uni_is_vacated_space, is_vacated_space,
    input  car_entered, is_uni_car_entered, car_exited, is_uni_car_exited,
           barrier_in_open, barrier_out_open, entry_denied
`ifdef PARKING_GATE_TIMEOUT_EN
    , input gate_timeout
`endif
  );

  // Controller side.
  modport slave (
    input  loop_in_raw, loop_out_raw, card_in_valid, card_in_uni,
           card_out_valid, card_out_uni, uni_is_vacated_space, is_vacated_space,
    output car_entered, is_uni_car_entered, car_exited, is_uni_car_exited,
           barrier_in_open, barrier_out_open, entry_denied
`ifdef PARKING_GATE_TIMEOUT_EN
    , output gate_timeout
`endif
  );
endinterface

// File: rtl/parking_gate_lane.sv
// One gate lane: loop synchroniser, debounce, card wait, admission, barrier
// and strobe sequencing. Watchdog in OPEN with PARKING_GATE_TIMEOUT_EN.
module parking_gate_lane
  import parking_pkg::*;
#(
  parameter bit          IS_ENTRY         = 1'b1,
  parameter int unsigned DEBOUNCE_CYCLES  = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned CARD_WAIT_CYCLES = DEF_CARD_WAIT_CYCLES,
  parameter int unsigned PULSE_CYCLES     = DEF_PULSE_CYCLES,
  parameter int unsigned OPEN_TIMEOUT     = DEF_OPEN_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic loop_raw,
  input  logic card_valid,
  input  logic card_uni,
  input  logic uni_vacant,
  input  logic pub_vacant,
  input  logic grant,
  output logic req,
  output logic strobing,
  output logic strobe,
  output logic is_uni,
  output logic barrier_open,
  output logic denied
`ifdef PARKING_GATE_TIMEOUT_EN
  , output logic timeout
`endif
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned CW_W = $clog2(CARD_WAIT_CYCLES + 1);
  localparam int unsigned PL_W = $clog2(PULSE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW_W-1:0] CW_LAST = CW_W'(CARD_WAIT_CYCLES - 1);
  localparam logic [PL_W-1:0] PL_LAST = PL_W'(PULSE_CYCLES - 1);

  logic            sync1_r, sync2_r;
  logic            level_r;
  logic [DB_W-1:0] db_cnt_r;
  logic [CW_W-1:0] card_cnt_r;
  logic [PL_W-1:0] pulse_cnt_r;
  lane_state_e     state_r;
  logic            uni_r, strobe_r, cls_r, barrier_r, denied_r;
  logic            ok_s;

`ifdef PARKING_GATE_TIMEOUT_EN
  localparam int unsigned OT_W = $clog2(OPEN_TIMEOUT + 1);
  localparam logic [OT_W-1:0] OT_LAST = OT_W'(OPEN_TIMEOUT - 1);
  logic [OT_W-1:0] open_cnt_r;
  logic            timeout_r;
  assign timeout = timeout_r;
`endif

  assign ok_s         = lane_ok(IS_ENTRY, uni_r, uni_vacant, pub_vacant);
  assign req          = (state_r == STROBE_REQ);
  assign strobing     = (state_r == STROBE);
  assign strobe       = strobe_r;
  assign is_uni       = cls_r;
  assign barrier_open = barrier_r;
  assign denied       = denied_r;

  // Two-flop synchroniser for the asynchronous loop sensor.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= loop_raw;
      sync2_r <= sync1_r;
    end
  end

  // Debounce: accept a new level after DEBOUNCE_CYCLES equal differing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_r  <= 1'b0;
      db_cnt_r <= {DB_W{1'b0}};
    end else if (sync2_r == level_r) begin
      db_cnt_r <= {DB_W{1'b0}};
    end else if (db_cnt_r == DB_LAST) begin
      level_r  <= sync2_r;
      db_cnt_r <= {DB_W{1'b0}};
    end else begin
      db_cnt_r <= db_cnt_r + DB_W'(1);
    end
  end

  // Lane state machine with registered barrier, strobe, class and pulse outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      card_cnt_r  <= {CW_W{1'b0}};
      pulse_cnt_r <= {PL_W{1'b0}};
      uni_r       <= 1'b0;
      strobe_r    <= 1'b0;
      cls_r       <= 1'b0;
      barrier_r   <= 1'b0;
      denied_r    <= 1'b0;
`ifdef PARKING_GATE_TIMEOUT_EN
      open_cnt_r  <= {OT_W{1'b0}};
      timeout_r   <= 1'b0;
`endif
    end else begin
      denied_r <= 1'b0;
`ifdef PARKING_GATE_TIMEOUT_EN
      timeout_r <= 1'b0;
`endif
      case (state_r)
        IDLE: begin
          card_cnt_r <= {CW_W{1'b0}};
          if (level_r) begin
            state_r <= CARD;
          end else begin
            state_r <= IDLE;
          end
        end
        CARD: begin
          if (card_valid) begin
            uni_r   <= card_uni;
            state_r <= CHECK;
          end else if (card_cnt_r == CW_LAST) begin
            uni_r   <= 1'b0;
            state_r <= CHECK;
          end else begin
            card_cnt_r <= card_cnt_r + CW_W'(1);
          end
        end
        CHECK: begin
          if (ok_s) begin
            barrier_r <= 1'b1;
            state_r   <= OPEN;
`ifdef PARKING_GATE_TIMEOUT_EN
            open_cnt_r <= {OT_W{1'b0}};
`endif
          end else begin
            denied_r <= 1'b1;
            state_r  <= DRAIN;
          end
        end
        OPEN: begin
          if (!level_r) begin
            barrier_r <= 1'b0;
            state_r   <= STROBE_REQ;
`ifdef PARKING_GATE_TIMEOUT_EN
          end else if (open_cnt_r == OT_LAST) begin
            barrier_r <= 1'b0;
            timeout_r <= 1'b1;
            state_r   <= DRAIN;
          end else begin
            open_cnt_r <= open_cnt_r + OT_W'(1);
`else
          end else begin
            state_r <= OPEN;
`endif
          end
        end
        STROBE_REQ: begin
          if (grant) begin
            strobe_r    <= 1'b1;
            cls_r       <= uni_r;
            pulse_cnt_r <= {PL_W{1'b0}};
            state_r     <= STROBE;
          end else begin
            state_r <= STROBE_REQ;
          end
        end
        STROBE: begin
          if (pulse_cnt_r == PL_LAST) begin
            strobe_r <= 1'b0;
            state_r  <= HOLD;
          end else begin
            pulse_cnt_r <= pulse_cnt_r + PL_W'(1);
          end
        end
        HOLD: begin
          // Class stays valid one cycle past the falling edge the counter uses.
          cls_r   <= 1'b0;
          state_r <= IDLE;
        end
        DRAIN: begin
          if (!level_r) begin
            state_r <= IDLE;
          end else begin
            state_r <= DRAIN;
          end
        end
        default: begin
          state_r   <= IDLE;
          barrier_r <= 1'b0;
          strobe_r  <= 1'b0;
          cls_r     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/parking_gate_controller.sv
// Parking gate front-end: entry and exit lanes plus a strobe arbiter that keeps
// the car_entered / car_exited pulse windows disjoint (entry wins ties).
// Optional OPEN watchdog and gate_timeout output: PARKING_GATE_TIMEOUT_EN.
module parking_gate_controller
  import parking_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES  = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned CARD_WAIT_CYCLES = DEF_CARD_WAIT_CYCLES,
  parameter int unsigned PULSE_CYCLES     = DEF_PULSE_CYCLES,
  parameter int unsigned OPEN_TIMEOUT     = DEF_OPEN_TIMEOUT
) (
  input  logic           clk,
  input  logic           rst,
  parking_gate_if.slave  gate
);

  logic req_in_s, req_out_s, strobing_in_s, strobing_out_s;
  logic grant_in_s, grant_out_s;
  logic denied_in_s, denied_out_s;

  // A lane may start its pulse while the other is in HOLD, never during its
  // pulse; with both waiting, entry goes first.
  assign grant_in_s  = req_in_s & ~strobing_out_s;
  assign grant_out_s = req_out_s & ~req_in_s & ~strobing_in_s;

  // Exit lane never refuses, so only the entry lane contributes in practice.
  assign gate.entry_denied = denied_in_s | denied_out_s;

`ifdef PARKING_GATE_TIMEOUT_EN
  logic timeout_in_s, timeout_out_s;
  assign gate.gate_timeout = timeout_in_s | timeout_out_s;
`endif

  parking_gate_lane #(
    .IS_ENTRY(1'b1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CARD_WAIT_CYCLES(CARD_WAIT_CYCLES), .PULSE_CYCLES(PULSE_CYCLES),
    .OPEN_TIMEOUT(OPEN_TIMEOUT)
  ) u_entry (
    .clk(clk), .rst(rst),
    .loop_raw(gate.loop_in_raw),
    .card_valid(gate.card_in_valid), .card_uni(gate.card_in_uni),
    .uni_vacant(gate.uni_is_vacated_space), .pub_vacant(gate.is_vacated_space),
    .grant(grant_in_s), .req(req_in_s), .strobing(strobing_in_s),
    .strobe(gate.car_entered), .is_uni(gate.is_uni_car_entered),
    .barrier_open(gate.barrier_in_open), .denied(denied_in_s)
`ifdef PARKING_GATE_TIMEOUT_EN
    , .timeout(timeout_in_s)
`endif
  );

  parking_gate_lane #(
    .IS_ENTRY(1'b0), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CARD_WAIT_CYCLES(CARD_WAIT_CYCLES), .PULSE_CYCLES(PULSE_CYCLES),
    .OPEN_TIMEOUT(OPEN_TIMEOUT)
  ) u_exit (
    .clk(clk), .rst(rst),
    .loop_raw(gate.loop_out_raw),
    .card_valid(gate.card_out_valid), .card_uni(gate.card_out_uni),
    .uni_vacant(gate.uni_is_vacated_space), .pub_vacant(gate.is_vacated_space),
    .grant(grant_out_s), .req(req_out_s), .strobing(strobing_out_s),
    .strobe(gate.car_exited), .is_uni(gate.is_uni_car_exited),
    .barrier_open(gate.barrier_out_open), .denied(denied_out_s)
`ifdef PARKING_GATE_TIMEOUT_EN
    , .timeout(timeout_out_s)
`endif
  );

endmodule
